// File: rtl/seg7_scan_if.sv
// Digit/control inputs and multiplexed display outputs of the 4-digit
// 7-segment scan driver.
interface seg7_scan_if;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       lz_blank;
  logic       colon_en;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output dig3, dig2, dig1, dig0, lz_blank, colon_en, blink,
    input  an, seg, dp
  );

  modport slave (
    input  dig3, dig2, dig1, dig0, lz_blank, colon_en, blink,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit 7-segment driver with per-frame
// shadowing, leading-zero blanking, colon dp and expiry blink.
module seg7_digit_dec (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0111111;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic                           rst_q;
  logic                           clr;
  logic [CW-1:0]                  cnt;
  logic [1:0]                     sel;
  logic                           tick;
  logic                           frame_end;
  logic [NUM_DIGITS-1:0][3:0]     dig_in;
  logic [NUM_DIGITS-1:0][3:0]     sh_dig;
  logic                           sh_lz;
  logic                           sh_colon;
  logic                           sh_blink;
  logic                           phase_on;
  logic [FW-1:0]                  frm_cnt;
  logic [NUM_DIGITS-1:0][6:0]     dec_seg;
  logic [NUM_DIGITS-1:0]          is_zero;
  logic [NUM_DIGITS-1:0]          lz_kill;
  logic                           slot_blank;
  logic [3:0]                     an_q;
  logic [6:0]                     seg_q;
  logic                           dp_q;

  assign dig_in = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};

  // Reset is stretched by one cycle so the display stays dark in the cycle
  // after release and the first slot still gets its full dwell time.
  always_ff @(posedge clk) rst_q <= reset;
  assign clr = reset | rst_q;

  assign tick      = (cnt == CNT_MAX);
  assign frame_end = tick && (sel == 2'd3);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      sel <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Everything visible is taken from shadow copies refreshed only at frame
  // boundaries, so a frame never mixes old and new digits.
  always_ff @(posedge clk) begin
    if (clr) begin
      sh_dig   <= '0;
      sh_lz    <= 1'b0;
      sh_colon <= 1'b0;
      sh_blink <= 1'b0;
      phase_on <= 1'b1;
      frm_cnt  <= '0;
    end else if (frame_end) begin
      sh_dig   <= dig_in;
      sh_lz    <= bus.lz_blank;
      sh_colon <= bus.colon_en;
      sh_blink <= bus.blink;
      if (!bus.blink || !sh_blink) begin
        phase_on <= 1'b1;
        frm_cnt  <= '0;
      end else if (frm_cnt == FRM_MAX) begin
        phase_on <= ~phase_on;
        frm_cnt  <= '0;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      seg7_digit_dec u_dec (
        .bcd (sh_dig[g]),
        .seg (dec_seg[g])
      );
      assign is_zero[g] = (sh_dig[g] == 4'd0);
      // A digit is a leading zero only if every more significant digit is too.
      if (g == NUM_DIGITS - 1) begin : g_top
        assign lz_kill[g] = sh_lz & is_zero[g];
      end else if (g == 0) begin : g_units
        assign lz_kill[g] = 1'b0;
      end else begin : g_mid
        assign lz_kill[g] = lz_kill[g+1] & is_zero[g];
      end
    end
  endgenerate

  assign slot_blank = !phase_on || lz_kill[sel];

  always_ff @(posedge clk) begin
    if (clr || slot_blank) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << sel);
      seg_q <= dec_seg[sel];
      dp_q  <= !((sel == 2'd2) && sh_colon);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-level reference model checked every cycle,
// a table of display vectors, and directed reset/tearing/blink sequences.
module tb_seg7_scan_driver;
  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_if bus ();

  seg7_scan_driver #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]      d3, d2, d1, d0;
    logic            lz, col, bl;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] dec_tab [16];

  // Reference model: display index since the last clear, frame shadow, blink run
  int         m_k;
  int         m_run;
  logic       m_rprev = 1'b0;
  logic [3:0] m_sd [4];
  logic       m_lz, m_col;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  task automatic cyc();
    logic       ci_r, ci_lz, ci_col, ci_bl;
    logic [3:0] ci_d [4];
    int         slot;
    bit         on, lzb;
    ci_r = reset; ci_lz = bus.lz_blank; ci_col = bus.colon_en; ci_bl = bus.blink;
    ci_d[0] = bus.dig0; ci_d[1] = bus.dig1; ci_d[2] = bus.dig2; ci_d[3] = bus.dig3;
    @(posedge clk);
    if (ci_r || m_rprev) begin
      m_k = 0; m_run = 0; m_lz = 0; m_col = 0;
      for (int j = 0; j < 4; j++) m_sd[j] = 4'd0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      slot = (m_k / DIV) % 4;
      on   = (m_run == 0) || (((m_run - 1) / BF) % 2 == 0);
      lzb  = 0;
      if (m_lz && slot != 0) begin
        lzb = 1;
        for (int j = slot; j < 4; j++) if (m_sd[j] != 4'd0) lzb = 0;
      end
      if (!on || lzb) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << slot);
        e_seg = dec_tab[m_sd[slot]];
        e_dp  = !(slot == 2 && m_col);
      end
      if (m_k % FRAME == FRAME - 1) begin
        for (int j = 0; j < 4; j++) m_sd[j] = ci_d[j];
        m_lz  = ci_lz;
        m_col = ci_col;
        m_run = ci_bl ? m_run + 1 : 0;
      end
      m_k++;
    end
    m_rprev = ci_r;
    @(negedge clk);
    n_tests++;
    if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
      n_fail++;
      $display("FAIL model t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               $time, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic expect_out(input string nm, input logic [3:0] a, input logic [6:0] s,
                            input logic d);
    n_tests++;
    if ({bus.an, bus.seg, bus.dp} !== {a, s, d}) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               nm, bus.an, bus.seg, bus.dp, a, s, d);
    end
  endtask

  task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input logic lz, input logic col,
                        input logic bl);
    bus.dig3 = d3; bus.dig2 = d2; bus.dig1 = d1; bus.dig0 = d0;
    bus.lz_blank = lz; bus.colon_en = col; bus.blink = bl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(1);
  endtask

  vec_t       tbl [7];
  logic [8:1] lit_exp;

  initial begin
    dec_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    tbl[0] = '{4'h4, 4'h3, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0011001, 7'b0110000, 7'b1000000, 7'b0010000}, 4'b1111};
    tbl[1] = '{4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0,
               {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'h7F, 7'h7F, 7'h7F, 7'b0010010}, 4'b1111};
    tbl[2] = '{4'h0, 4'h0, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0,
               {4'b1111, 4'b1111, 4'b1101, 4'b1110},
               {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'b1111};
    tbl[3] = '{4'h1, 4'h2, 4'hC, 4'h4, 1'b0, 1'b1, 1'b0,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111001, 7'b0100100, 7'b0111111, 7'b0011001}, 4'b1011};
    tbl[4] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0,
               {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    tbl[5] = '{4'h8, 4'h6, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0,
               {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0000000, 7'b0000010, 7'b1111000, 7'b0111111}, 4'b1111};
    tbl[6] = '{4'h0, 4'h5, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1,
               {4'b1111, 4'b1011, 4'b1101, 4'b1110},
               {7'h7F, 7'b0010010, 7'b1000000, 7'b1111001}, 4'b1111};
    lit_exp = 8'b0011_0011;

    // Reset release with all-zero digits
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc(); expect_out("rst_c0", 4'hF, 7'h7F, 1'b1);
    cyc(); expect_out("rst_c1", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
    cyc(); expect_out("rst_after", 4'hF, 7'h7F, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out("rst_slot0", 4'b1110, 7'b1000000, 1'b1);
    end
    cyc(); expect_out("rst_slot1", 4'b1101, 7'b1000000, 1'b1);

    // Table vectors: second frame after reset shows the held inputs
    for (int i = 0; i < 7; i++) begin
      set_in(tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0, tbl[i].lz, tbl[i].col, tbl[i].bl);
      do_reset();
      run(FRAME);
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < DIV; c++) begin
          cyc();
          expect_out($sformatf("tbl%0d_slot%0d", i, s), tbl[i].an[s], tbl[i].seg[s], tbl[i].dp[s]);
        end
    end

    // Inputs changing mid-frame only appear after the frame boundary
    set_in(4, 3, 0, 9, 0, 0, 0);
    do_reset();
    run(FRAME + DIV + 1);
    set_in(1, 2, 3, 4, 0, 0, 0);
    run(3);   expect_out("tear_s1_old", 4'b1101, 7'b1000000, 1'b1);
    run(DIV); expect_out("tear_s2_old", 4'b1011, 7'b0110000, 1'b1);
    run(DIV); expect_out("tear_s3_old", 4'b0111, 7'b0011001, 1'b1);
    cyc();    expect_out("tear_s0_new", 4'b1110, 7'b0011001, 1'b1);
    run(3 + DIV); expect_out("tear_s1_new", 4'b1101, 7'b0110000, 1'b1);

    // Blink over 8 frames, then reset in the middle of frame 6
    set_in(0, 0, 0, 0, 0, 0, 1);
    do_reset();
    run(FRAME);
    for (int f = 1; f <= 8; f++) begin
      cyc();
      expect_out($sformatf("blink_f%0d", f), lit_exp[f] ? 4'b1110 : 4'hF,
                 lit_exp[f] ? 7'b1000000 : 7'h7F, 1'b1);
      run(FRAME - 1);
    end
    do_reset();
    run(FRAME * 6 + 7);
    reset = 1'b1;
    cyc(); expect_out("mid_rst0", 4'hF, 7'h7F, 1'b1);
    reset = 1'b0;
    cyc(); expect_out("mid_rst1", 4'hF, 7'h7F, 1'b1);
    cyc(); expect_out("mid_rst_on", 4'b1110, 7'b1000000, 1'b1);

    // Randomized inputs and occasional resets against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.dig3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.dig2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.dig1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.dig0 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 63) == 0) bus.lz_blank = ~bus.lz_blank;
      if ($urandom_range(0, 63) == 0) bus.colon_en = ~bus.colon_en;
      if ($urandom_range(0, 199) == 0) bus.blink = ~bus.blink;
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
